load_store_unit: RTL

Multi-cycle load/store unit sitting directly downstream of the ALU in the RV32I core. It takes the ALU result as the effective address for load (opcode 7'h03) and store (opcode 7'h23) instructions, drives a request/grant/response data-memory port with byte enables, aligns and sign/zero-extends load data, and holds the core stalled until the access completes. Misaligned and illegal-width accesses are flagged instead of issued.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/load_extend.sv | 39 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared opcodes, func3 encodings, FSM states and access helpers for the load/store unit
//
// Purpose: common definitions used by load_store_unit and load_extend.
//   OPC_LOAD / OPC_STORE : RV32I major opcodes handled by the unit
//   load_f3_t / store_f3_t: legal func3 width/sign encodings
//   lsu_state_t           : access sequencing states
//   func3_legal, misaligned, byte_enable: access classification helpers

package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {SB, SH, SW};
    else          return f3 inside {LB, LH, LW, LBU, LHU};
  endfunction

  // func3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select with sign/zero extension
//
// Purpose: picks the byte/halfword addressed by addr_lo out of a read word and
// extends it to DW bits according to the load func3.
// Ports:
//   func3   in  3   load width/sign (LB, LH, LW, LBU, LHU)
//   addr_lo in  2   low address bits selecting the lane
//   rdata   in  DW  read data word from memory
//   result  out DW  extended load value

module load_extend
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    func3,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // Halfwords are always aligned here, so only addr_lo[1] matters.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (load_f3_t'(func3))
      LB:      result = {{(DW-8){byte_sel[7]}}, byte_sel};
      LBU:     result = {{(DW-8){1'b0}}, byte_sel};
      LH:      result = {{(DW-16){half_sel[15]}}, half_sel};
      LHU:     result = {{(DW-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV32I load/store unit with req/gnt/rvalid memory port
//
// Purpose: issues one data-memory access per load/store instruction, stalls the
// core until it completes, and returns aligned/extended load data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             instruction is a load/store (held while stall_o)
//   opcode_i, func3_i   instruction opcode and width/sign field
//   addr_i              effective address from the ALU
//   store_data_i        rs2 value for stores
//   stall_o             freeze PC/register file
//   done_o              one-cycle completion pulse
//   load_data_o         last completed load result
//   err_o               one-cycle pulse for misaligned/illegal access
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o   request payload
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i                     memory handshake/response

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [6:0]    opcode_i,
  input  logic [2:0]    func3_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] store_data_i,
  output logic          stall_o,
  output logic          done_o,
  output logic [DW-1:0] load_data_o,
  output logic          err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  lsu_state_t state_q, state_d;

  logic          is_load, is_store, op_valid, access_ok, accept;
  logic [DW-1:0] wdata_rep;
  logic [DW-1:0] ext_data;

  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    addr_lo_q;
  logic [DW-1:0] load_q;

  assign is_load   = opcode_i == OPC_LOAD;
  assign is_store  = opcode_i == OPC_STORE;
  assign op_valid  = start_i && (is_load || is_store);
  assign access_ok = func3_legal(is_store, func3_i) && !misaligned(func3_i, addr_i[1:0]);

  always_comb begin
    case (func3_i[1:0])
      2'b00:   wdata_rep = {4{store_data_i[7:0]}};
      2'b01:   wdata_rep = {2{store_data_i[15:0]}};
      default: wdata_rep = store_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The IDLE-state outputs are combinational on start_i; they are qualified by
  // rst_n so stall/err also drop immediately while reset is held.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    stall_o   = 1'b0;
    err_o     = 1'b0;
    done_o    = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && op_valid) begin
          if (access_ok) begin
            accept  = 1'b1;
            stall_o = 1'b1;
            state_d = REQ;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_gnt_i) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is captured once on acceptance so it stays stable across grant stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_lo_q <= '0;
    end else if (accept) begin
      addr_q    <= {addr_i[AW-1:2], 2'b00};
      be_q      <= byte_enable(func3_i, addr_i[1:0]);
      wdata_q   <= wdata_rep;
      we_q      <= is_store;
      f3_q      <= func3_i;
      addr_lo_q <= addr_i[1:0];
    end
  end

  load_extend #(.DW(DW)) u_load_extend (
    .func3   (f3_q),
    .addr_lo (addr_lo_q),
    .rdata   (mem_rdata_i),
    .result  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               load_q <= '0;
    else if (state_q == WAIT && mem_rvalid_i) load_q <= ext_data;
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign load_data_o = load_q;

endmodule
